// File: rtl/alu_pkg.sv
// Shared ALU select codes, funct3 encodings and execute-stage bundles.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'hA;
  localparam logic [3:0] ALU_SLT  = 4'hC;
  localparam logic [3:0] ALU_SLTU = 4'hE;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      sel;
    logic            illegal;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            cout;
    logic            of;
    logic            zf;
    logic            illegal;
  } ex_wb_t;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; carry/overflow only meaningful for add/sub.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      sel_i,
  output logic [XLEN-1:0] result_o,
  output logic            carry_out_flag_o,
  output logic            overflow_o,
  output logic            zero_flag_o
);

  logic            is_sub;
  logic [XLEN-1:0] bb;
  logic [XLEN:0]   sum;

  assign is_sub = (sel_i == ALU_SUB);
  assign bb     = is_sub ? ~b_i : b_i;
  // Subtract as a + ~b + 1, so carry-out means "no borrow".
  assign sum    = {1'b0, a_i} + {1'b0, bb}
                + {{XLEN{1'b0}}, is_sub};

  always_comb begin
    result_o         = '0;
    carry_out_flag_o = 1'b0;
    overflow_o       = 1'b0;
    unique case (sel_i)
      ALU_ADD, ALU_SUB: begin
        result_o         = sum[XLEN-1:0];
        carry_out_flag_o = sum[XLEN];
        overflow_o       = (a_i[XLEN-1] == bb[XLEN-1])
                        && (sum[XLEN-1] != a_i[XLEN-1]);
      end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}},
                            $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      default:  result_o = '0;
    endcase
  end

  assign zero_flag_o = ~|result_o;

endmodule

// File: rtl/alu_decode.sv
// funct3/funct7 to ALU select mapping; SRA/SRAI flagged as unsupported.
module alu_decode
  import alu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       is_imm_i,
  output logic [3:0] sel_o,
  output logic       illegal_o
);

  always_comb begin
    sel_o     = ALU_ADD;
    illegal_o = 1'b0;
    unique case (funct3_i)
      F3_ADD:  sel_o = (funct7_5_i && !is_imm_i) ? ALU_SUB : ALU_ADD;
      F3_SLL:  sel_o = ALU_SLL;
      F3_SLT:  sel_o = ALU_SLT;
      F3_SLTU: sel_o = ALU_SLTU;
      F3_XOR:  sel_o = ALU_XOR;
      F3_SR: begin
        if (funct7_5_i) illegal_o = 1'b1;
        else            sel_o     = ALU_SRL;
      end
      F3_OR:   sel_o = ALU_OR;
      F3_AND:  sel_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-register execute stage: operand register, ALU, result register.
module alu_exec_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic            in_is_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_cout,
  output logic            out_of,
  output logic            out_zf,
  output logic            out_illegal,
  output logic [RD_W-1:0] out_rd
);

  import alu_pkg::*;

  id_ex_t          s1_d, s1_q;
  logic            s1_valid_d, s1_valid_q;
  logic [RD_W-1:0] s1_rd_d, s1_rd_q;

  ex_wb_t          s2_d, s2_q;
  logic            out_valid_d, out_valid_q;
  logic [RD_W-1:0] out_rd_d, out_rd_q;

  logic [3:0]      dec_sel;
  logic            dec_ill;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_c, alu_v, alu_z;
  logic            s2_free, s1_adv, in_fire;

  alu_decode u_dec (
    .funct3_i   (in_funct3),
    .funct7_5_i (in_funct7_5),
    .is_imm_i   (in_is_imm),
    .sel_o      (dec_sel),
    .illegal_o  (dec_ill)
  );

  alu u_alu (
    .a_i              (s1_q.a),
    .b_i              (s1_q.b),
    .sel_i            (s1_q.sel),
    .result_o         (alu_res),
    .carry_out_flag_o (alu_c),
    .overflow_o       (alu_v),
    .zero_flag_o      (alu_z)
  );

  assign op_b     = in_is_imm ? in_imm : in_rs2;
  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !rst && !flush
                 && (!s1_valid_q || s2_free);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s1_rd_d    = s1_rd_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_d.a       = in_rs1;
      s1_d.b       = op_b;
      s1_d.sel     = dec_sel;
      s1_d.illegal = dec_ill;
      s1_rd_d      = in_rd;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Unsupported ops still retire, but with result and flags zeroed.
  always_comb begin
    out_valid_d = out_valid_q;
    s2_d        = s2_q;
    out_rd_d    = out_rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (s1_adv) begin
      out_valid_d  = 1'b1;
      s2_d.illegal = s1_q.illegal;
      s2_d.result  = s1_q.illegal ? '0 : alu_res;
      s2_d.cout    = !s1_q.illegal && alu_c;
      s2_d.of      = !s1_q.illegal && alu_v;
      s2_d.zf      = !s1_q.illegal && alu_z;
      out_rd_d     = s1_rd_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s1_rd_q     <= '0;
      out_valid_q <= 1'b0;
      s2_q        <= '0;
      out_rd_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s1_rd_q     <= s1_rd_d;
      out_valid_q <= out_valid_d;
      s2_q        <= s2_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = s2_q.result;
  assign out_cout    = s2_q.cout;
  assign out_of      = s2_q.of;
  assign out_zf      = s2_q.zf;
  assign out_illegal = s2_q.illegal;
  assign out_rd      = out_rd_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table plus stall/flush/reset runs.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic        in_is_imm;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_cout;
  logic        out_of;
  logic        out_zf;
  logic        out_illegal;
  logic [4:0]  out_rd;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct3   (in_funct3),
    .in_funct7_5 (in_funct7_5),
    .in_is_imm   (in_is_imm),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_rd       (in_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_cout    (out_cout),
    .out_of      (out_of),
    .out_zf      (out_zf),
    .out_illegal (out_illegal),
    .out_rd      (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        f7;
    logic        is_imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vt[16];
  vec_t bp[3];

  function automatic vec_t mk(
    input string nm, input logic [2:0] f3,
    input logic f7, input logic im,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] i, input logic [4:0] rd,
    input logic [31:0] res, input logic c,
    input logic v, input logic z, input logic ill);
    vec_t t;
    t.name = nm; t.f3 = f3; t.f7 = f7;
    t.is_imm = im; t.rs1 = a; t.rs2 = b;
    t.imm = i; t.rd = rd; t.res = res;
    t.c = c; t.v = v; t.z = z; t.ill = ill;
    return t;
  endfunction

  function automatic logic [41:0] exp_of(input vec_t t);
    return {1'b1, t.ill, t.c, t.v, t.z, t.rd, t.res};
  endfunction

  function automatic logic [41:0] obs();
    return {out_valid, out_illegal, out_cout, out_of,
            out_zf, out_rd, out_result};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input vec_t t);
    in_funct3   = t.f3;
    in_funct7_5 = t.f7;
    in_is_imm   = t.is_imm;
    in_rs1      = t.rs1;
    in_rs2      = t.rs2;
    in_imm      = t.imm;
    in_rd       = t.rd;
  endtask

  logic seen;

  initial begin
    vt[0]  = mk("addi", 3'b000, 0, 1, 32'd5, 32'd0,
                32'hFFFFFFF9, 5'd1, 32'hFFFFFFFE, 0, 0, 0, 0);
    vt[1]  = mk("sub_eq", 3'b000, 1, 0, 32'd3, 32'd3,
                32'd0, 5'd2, 32'd0, 1, 0, 1, 0);
    vt[2]  = mk("add_ovf", 3'b000, 0, 0, 32'h7FFFFFFF,
                32'd1, 32'd0, 5'd3, 32'h80000000, 0, 1, 0, 0);
    vt[3]  = mk("addi_f7", 3'b000, 1, 1, 32'd10,
                32'h0000DEAD, 32'd3, 5'd4, 32'd13, 0, 0, 0, 0);
    vt[4]  = mk("sll", 3'b001, 0, 0, 32'd1, 32'h24,
                32'd0, 5'd5, 32'h10, 0, 0, 0, 0);
    vt[5]  = mk("slt", 3'b010, 0, 0, 32'hFFFFFFFF, 32'd1,
                32'd0, 5'd6, 32'd1, 0, 0, 0, 0);
    vt[6]  = mk("sltu", 3'b011, 0, 0, 32'hFFFFFFFF, 32'd1,
                32'd0, 5'd7, 32'd0, 0, 0, 1, 0);
    vt[7]  = mk("xor", 3'b100, 0, 0, 32'hF0F0F0F0,
                32'hFFFF0000, 32'd0, 5'd8, 32'h0F0FF0F0,
                0, 0, 0, 0);
    vt[8]  = mk("srl", 3'b101, 0, 0, 32'h80000000,
                32'h1F, 32'd0, 5'd9, 32'd1, 0, 0, 0, 0);
    vt[9]  = mk("or", 3'b110, 0, 0, 32'h00FF0000,
                32'h0000FF00, 32'd0, 5'd10, 32'h00FFFF00,
                0, 0, 0, 0);
    vt[10] = mk("and", 3'b111, 0, 0, 32'hFF00FF00,
                32'h0FF00FF0, 32'd0, 5'd11, 32'h0F000F00,
                0, 0, 0, 0);
    vt[11] = mk("srai_ill", 3'b101, 1, 1, 32'h80000000,
                32'd0, 32'd4, 5'd7, 32'd0, 0, 0, 0, 1);
    vt[12] = mk("add_wrap", 3'b000, 0, 0, 32'hFFFFFFFF,
                32'd1, 32'd0, 5'd12, 32'd0, 1, 0, 1, 0);
    vt[13] = mk("sub_ovf", 3'b000, 1, 0, 32'h80000000,
                32'd1, 32'd0, 5'd13, 32'h7FFFFFFF, 1, 1, 0, 0);
    vt[14] = mk("sra_ill", 3'b101, 1, 0, 32'hFFFFFFFF,
                32'd1, 32'd0, 5'd14, 32'd0, 0, 0, 0, 1);
    vt[15] = mk("slli", 3'b001, 0, 1, 32'd3, 32'd0,
                32'd2, 5'd15, 32'hC, 0, 0, 0, 0);

    bp[0] = mk("bp_and", 3'b111, 0, 0, 32'hFF00FF00,
               32'h0FF00FF0, 32'd0, 5'd1, 32'h0F000F00,
               0, 0, 0, 0);
    bp[1] = mk("bp_or", 3'b110, 0, 0, 32'h11, 32'h100,
               32'd0, 5'd2, 32'h111, 0, 0, 0, 0);
    bp[2] = mk("bp_xor", 3'b100, 0, 0, 32'h0000FFFF,
               32'h000000FF, 32'd0, 5'd3, 32'h0000FF00,
               0, 0, 0, 0);

    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    drv(vt[0]);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out", obs(), 0);
    chk("reset_rdy", in_ready, 0);
    rst = 1'b0;

    // single op at a time through both registers
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drv(vt[i]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 chk({vt[i].name, "_rdy"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk(vt[i].name, obs(), exp_of(vt[i]));
    end
    @(negedge clk);
    chk("idle_valid", out_valid, 0);

    // backpressure: two buffered, third waits
    out_ready = 1'b0;
    drv(bp[0]); in_valid = 1'b1;
    #1 chk("bp_rdy0", in_ready, 1);
    @(negedge clk);
    drv(bp[1]);
    #1 chk("bp_rdy1", in_ready, 1);
    @(negedge clk);
    drv(bp[2]);
    #1 chk("bp_rdy2_low", in_ready, 0);
    chk("bp_out0", obs(), exp_of(bp[0]));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("bp_stable", obs(), exp_of(bp[0]));
      chk("bp_hold_rdy", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out1", obs(), exp_of(bp[1]));
    @(negedge clk);
    chk("bp_out2", obs(), exp_of(bp[2]));
    @(negedge clk);
    chk("bp_drain", out_valid, 0);

    // flush with two in flight and a new op offered
    out_ready = 1'b0;
    drv(vt[0]); in_valid = 1'b1;
    @(negedge clk);
    drv(vt[1]);
    @(negedge clk);
    drv(vt[2]); flush = 1'b1;
    #1 chk("fl_rdy_low", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("fl_valid", out_valid, 0);
    chk("fl_rdy_after", in_ready, 1);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("fl_nothing_out", seen, 0);

    // reset mid-stall with two ops buffered
    out_ready = 1'b0;
    drv(bp[0]); in_valid = 1'b1;
    @(negedge clk);
    drv(bp[1]);
    @(negedge clk);
    drv(bp[2]); rst = 1'b1;
    #1 chk("rst_rdy_low", in_ready, 0);
    chk("rst_pre_out", obs(), exp_of(bp[0]));
    @(negedge clk);
    chk("rst_out_zero", obs(), 0);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("rst_rdy_after", in_ready, 1);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_nothing_out", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Two-register execute stage that wraps the 32-bit ALU. It accepts decoded-instruction fields and operand values over a valid/ready handshake, and maps RISC-V funct3/funct7 onto the ALU 4-bit select code. It registers the operands, runs the ALU combinationally, then captures the result and flags in an output register for the writeback stage. It sits between register-file read and writeback, and is the only instantiator of alu.

Parameters:
XLEN, 32, datapath width; only 32 is supported, and it exists for assertion/package sharing.
RD_W, 5, destination register index width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  upstream holds a valid op
in_ready  output  1  stage can accept this cycle
in_funct3  input  3  RISC-V funct3
in_funct7_5  input  1  instruction bit 30
in_is_imm  input  1  1 = OP-IMM form, use in_imm as B
in_rs1  input  32  operand A
in_rs2  input  32  operand B when in_is_imm=0
in_imm  input  32  sign-extended immediate
in_rd  input  5  destination index, passed through
flush  input  1  synchronous kill of all in-flight ops
out_valid  output  1  result register holds a valid op
out_ready  input  1  downstream accepts this cycle
out_result  output  32  ALU result
out_cout  output  1  ALU carry-out flag
out_of  output  1  ALU overflow flag
out_zf  output  1  ALU zero flag
out_illegal  output  1  op was unsupported; result forced 0
out_rd  output  5  destination index

Behaviour:
- Transfer rules: an input transfer happens when in_valid && in_ready; an output transfer happens when out_valid && out_ready.
- S1 (operand register) holds s1_valid, the A operand, the B operand, the 4-bit select, the illegal bit and rd.
- S2 (output register) holds out_valid and all out_* fields.
- Ready chaining:
  - s2_free = !out_valid || out_ready
  - s1 advances into S2 when s1_valid && s2_free
  - in_ready = !s1_valid || s2_free. in_ready is combinational and has no path from in_valid.
- Latency: an op accepted at edge k is captured in S2 at edge k+1 if S2 is free, so out_valid is asserted in cycle k+1.
- Throughput: one op per cycle with no bubbles. Under stall, at most 2 ops are buffered, and order is preserved.
- Stall behaviour: S1 and S2 contents hold stable while they are stalled. Outputs must not change while out_valid && !out_ready.
- Decode (combinational, from funct3):
  - 000: add = 0x0, or sub = 0x1 when funct7_5 && !is_imm. For ADDI, funct7_5 is ignored.
  - 001: sll = 0x8
  - 010: slt = 0xC
  - 011: sltu = 0xE
  - 100: xor = 0x6
  - 101: srl = 0xA
  - 110: or = 0x4
  - 111: and = 0x2
- Illegal op: funct3=101 with funct7_5=1 (SRA/SRAI) is unsupported. The select is forced to add and the illegal bit is set. In S2, out_result, out_cout, out_of and out_zf are forced to 0, out_illegal=1, and out_rd passes through.
- B operand selection: B = in_is_imm ? in_imm : in_rs2. The ALU itself uses only B[4:0] for shifts, so there is no extra masking.
- Flag capture: S2 captures the ALU's carry_out_flag, overflow and zero_flag unchanged. The ALU already zeroes carry and overflow for ops where they do not apply.
- Flush: at the edge where flush=1, s1_valid and out_valid clear.
  - in_ready is forced to 0 while flush=1, so no op is accepted in the flush cycle even if in_valid=1.
  - Flush overrides an out transfer in the same cycle; the transfer is still consumed by the downstream and not replayed.
- Reset: at the edge where rst=1, all valid bits, data fields and out_* outputs go to 0, so out_valid=0. While rst=1, in_ready=0. Reset mid-stall drops all in-flight ops. rst has priority over flush.
- Data registers: non-valid data registers may hold stale values, except that outputs are 0 after reset.

Decomposition:
- Package alu_pkg holds:
  - the ALU_ADD..ALU_SLTU 4-bit select constants (0x0, 0x1, 0x2, 0x4, 0x6, 0x8, 0xA, 0xC, 0xE)
  - the F3_* funct3 constants
  - XLEN
- Sub-module alu_decode is combinational. It takes funct3, funct7_5 and is_imm, and produces select[3:0] and illegal.
- The stage instantiates alu_decode and alu plus the two register stages.

Test Plan:
- ADDI: rs1=5, imm=0xFFFFFFF9, funct3=000, is_imm=1, out_ready=1 -> next cycle out_result=0xFFFFFFFE, out_zf=0, out_of=0.
- SUB: rs1=3, rs2=3, funct7_5=1 -> out_result=0, out_zf=1, out_cout=1. ADD 0x7FFFFFFF+1 -> out_result=0x80000000, out_of=1.
- Backpressure: hold out_ready=0 and issue 3 back-to-back ops (AND, OR, XOR) -> in_ready drops after 2 accepts, and out_* are stable while stalled. Release -> results arrive in order, and the third op is accepted the cycle after release.
- SRAI: funct3=101, funct7_5=1, is_imm=1, rd=7 -> out_illegal=1, out_result=0, out_rd=7.
- Flush: 2 ops in flight, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and neither in-flight op nor the flush-cycle op ever appears.
- Reset: assert rst during a stall with 2 ops buffered -> after the edge all outputs are 0 and out_valid=0. in_ready=1 one cycle after rst deasserts.
